irq_arbiter: RTL and testbench
==============================

# irq_arbiter

Multi-source external interrupt arbiter that sits between peripheral interrupt lines and the CSR unit's external interrupt input. It synchronises up to 16 sources and latches them as pending. It selects the highest-priority enabled pending source above a threshold and drives a single `intr_ext` request. Software acknowledges through a memory-mapped claim/complete handshake, and only one source is in service at a time.

## Interface
- `NUM_SRC`, default 8: number of interrupt sources, 1..16; source IDs are 1..NUM_SRC (ID 0 = none).
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `src_irq`  in  NUM_SRC  raw, asynchronous peripheral interrupt lines.
- `addr`  in  3  register select (word index).
- `data_in`  in  32  write data.
- `write_en`  in  1  register write strobe.
- `read_en`  in  1  register read strobe; qualifies the CLAIM side effect.
- `data_out`  out  32  combinational read data for `addr`.
- `intr_ext`  out  1  registered interrupt request to the CSR unit.

## Operation
- Registers (`addr`):
  - 0 ENABLE: bit i enables source i+1.
  - 1 PRIORITY: bits [2i+1:2i] hold source i+1; 0 means never selected.
  - 2 THRESHOLD [1:0].
  - 3 PENDING: read-only status; writing 1 to a bit clears that bit.
  - 4 CLAIM/COMPLETE.
  - 5 EDGE: only present with the macro.
  - Unused bits read 0; undefined addresses read 0 and ignore writes.
- Synchronisation: two flops per source, giving `s[i]`.
- Pending set, level mode: pending[i] is set every cycle `s[i]`=1.
- Pending set, edge mode: pending[i] is set on a 0→1 transition of `s[i]`.
- Set vs clear: a set condition in the same cycle as a clear (PENDING write or claim) wins.
- Arbitration, combinational:
  - Eligible = pending & ENABLE & (PRIORITY > THRESHOLD).
  - The winner is the highest PRIORITY; ties go to the lowest index.
  - `win_id` = index+1, or 0 if nothing is eligible.
- FSM states IDLE, REQ, SERVICE; reset → IDLE.
  - IDLE: if `win_id`≠0, go to REQ.
  - REQ: `intr_ext`=1.
    - A CLAIM read (`read_en`, addr 4) returns the current `win_id`; if nonzero, latch it as `svc_id`, clear that pending bit, and go to SERVICE.
    - If `win_id` becomes 0 (disabled or cleared), go back to IDLE.
  - SERVICE: `intr_ext`=0; new pending events keep latching.
    - A write to addr 4 with `data_in[4:0]`==`svc_id` completes the interrupt and returns to IDLE.
    - A write with a non-matching ID is ignored.
- CLAIM read outside REQ returns 0 and has no side effect.
- A COMPLETE write outside SERVICE is ignored.
- `data_out` at addr 4 reads `win_id` in IDLE/REQ and `svc_id` in SERVICE.
- Reads without `read_en` have no side effects.

## Timing
- Reset values: `intr_ext`=0; ENABLE, PRIORITY, THRESHOLD, PENDING and EDGE = 0; sync flops = 0; `svc_id`=0; state IDLE. `data_out`=0 for every address.
- Latency, `src_irq` rising → `intr_ext`=1 (source enabled and above threshold):
  - edges 1–2: sync;
  - edge 3: pending set;
  - edge 4: REQ, `intr_ext` asserted.
  - Total: 4 clock edges.
- A CLAIM read is valid in the same cycle (combinational `data_out`). The state update lands at the next edge, so `intr_ext` falls one cycle after the read cycle.
- COMPLETE takes effect at the next edge. A still-eligible source re-asserts `intr_ext` 2 edges after the COMPLETE (IDLE→REQ).
- A register write lands at the next edge. Arbitration uses post-write values from the cycle after the write.
- `reset` mid-service: everything returns to reset values at the next edge, and `intr_ext` drops.

## Configuration
- `IRQ_EDGE_EN` defined:
  - EDGE register exists at addr 5; bit i=1 selects edge mode for source i+1, reset 0 (level).
  - Extra per-source previous-value flop.
- Not defined:
  - All sources are level mode.
  - Addr 5 reads 0 and ignores writes.
  - No edge-detect logic.

## Test plan
- Reset, all-address sweep: every read returns 0x0 and `intr_ext`=0.
- Latency: ENABLE=0x01, PRIORITY=0x1, THRESHOLD=0; pulse `src_irq[0]` → `intr_ext`=1 exactly 4 edges later; CLAIM returns 1; `intr_ext`=0 next cycle; COMPLETE 1 → IDLE.
- Priority and tie-break: sources 2, 3 and 5 pending, priorities 2, 3, 3 → CLAIM returns 3; after COMPLETE 3, CLAIM returns 5, then 2.
- Threshold, disable and mismatched COMPLETE:
  - THRESHOLD=2 with only a priority-2 source pending → `intr_ext` stays 0.
  - Clearing ENABLE during REQ → back to IDLE, `intr_ext`=0.
  - COMPLETE with the wrong ID in SERVICE → state unchanged.
- Edge vs level (`IRQ_EDGE_EN`):
  - EDGE bit 0=1, `src_irq[0]` held high → after claim and complete, no re-request.
  - Level mode, same stimulus → re-request 2 edges after COMPLETE.
- Reset mid-service: assert `reset` in SERVICE → next edge: `intr_ext`=0, CLAIM reads 0, all registers 0.

Source files
------------

// File: rtl/irq_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : irq_arbiter
// Purpose  : External interrupt arbiter. It synchronises NUM_SRC raw
//            interrupt lines and latches them as pending. It selects the
//            highest-priority enabled pending source above THRESHOLD and
//            drives a single registered request (intr_ext) to the CSR unit.
//            Software claims and completes interrupts through a small
//            register file. Only one source is in service at a time.
//
// Ports    : clk       - sole clock, rising edge
//            reset     - synchronous, active-high reset
//            src_irq   - raw asynchronous interrupt lines (source i+1 on bit i)
//            addr      - register word index
//            data_in   - write data
//            write_en  - register write strobe
//            read_en   - read strobe; qualifies the CLAIM side effect
//            data_out  - combinational read data for addr
//            intr_ext  - registered interrupt request
//
// Register map (word index):
//            0 ENABLE     bit i enables source i+1
//            1 PRIORITY   bits [2i+1:2i] = priority of source i+1 (0 = never)
//            2 THRESHOLD  [1:0]
//            3 PENDING    read status; write 1 to clear a bit
//            4 CLAIM / COMPLETE
//            5 EDGE       bit i = 1 selects edge mode (only with IRQ_EDGE_EN)
//
// Options  : define IRQ_EDGE_EN to add the EDGE register and per-source
//            rising-edge detection. Without it every source is level mode
//            and address 5 reads 0 and ignores writes.
//
// Revision : 1.0 - initial release
// ============================================================================
module irq_arbiter #(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic [2:0]         addr,
  input  logic [31:0]        data_in,
  input  logic               write_en,
  input  logic               read_en,
  output logic [31:0]        data_out,
  output logic               intr_ext
);

  localparam int PRIO_W = 2 * NUM_SRC;

  localparam logic [2:0] ADDR_ENABLE    = 3'd0;
  localparam logic [2:0] ADDR_PRIORITY  = 3'd1;
  localparam logic [2:0] ADDR_THRESHOLD = 3'd2;
  localparam logic [2:0] ADDR_PENDING   = 3'd3;
  localparam logic [2:0] ADDR_CLAIM     = 3'd4;
`ifdef IRQ_EDGE_EN
  localparam logic [2:0] ADDR_EDGE      = 3'd5;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [NUM_SRC-1:0] sync1_q;
  logic [NUM_SRC-1:0] sync2_q;
  logic [NUM_SRC-1:0] enable_q;
  logic [PRIO_W-1:0]  prio_q;
  logic [1:0]         thresh_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] pending_d;
  logic [4:0]         svc_id_q;
  logic               intr_ext_q;
  state_e             state_q;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [NUM_SRC-1:0] set_vec;
  logic [NUM_SRC-1:0] clr_wr;
  logic [NUM_SRC-1:0] clr_claim;
  logic [4:0]         win_id;
  logic [1:0]         best_prio;
  logic               claim_fire;
  logic               complete_fire;
  logic               wr_hit_enable;
  logic               wr_hit_prio;
  logic               wr_hit_thresh;

  // Only a subset of data_in bits is meaningful for small NUM_SRC.
  logic unused_data_in;
  assign unused_data_in = ^data_in;

  // --------------------------------------------------------------------------
  // Two-flop synchroniser
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src_irq;
      sync2_q <= sync1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Pending set condition (level, or optionally rising edge)
  // --------------------------------------------------------------------------
`ifdef IRQ_EDGE_EN
  logic [NUM_SRC-1:0] edge_q;
  logic [NUM_SRC-1:0] prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      edge_q <= '0;
      prev_q <= '0;
    end else begin
      prev_q <= sync2_q;
      if (write_en && (addr == ADDR_EDGE)) begin
        edge_q <= data_in[NUM_SRC-1:0];
      end
    end
  end

  // Edge-mode sources only set on a 0->1 of the synchronised line.
  assign set_vec = sync2_q & (~edge_q | ~prev_q);
`else
  assign set_vec = sync2_q;
`endif

  // --------------------------------------------------------------------------
  // Configuration registers
  // --------------------------------------------------------------------------
  assign wr_hit_enable = write_en && (addr == ADDR_ENABLE);
  assign wr_hit_prio   = write_en && (addr == ADDR_PRIORITY);
  assign wr_hit_thresh = write_en && (addr == ADDR_THRESHOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q <= '0;
      prio_q   <= '0;
      thresh_q <= '0;
    end else begin
      if (wr_hit_enable) begin
        enable_q <= data_in[NUM_SRC-1:0];
      end
      if (wr_hit_prio) begin
        prio_q <= data_in[PRIO_W-1:0];
      end
      if (wr_hit_thresh) begin
        thresh_q <= data_in[1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Arbitration: strict ">" while scanning upward keeps ties on the lowest
  // index. best_prio starts at 0 and eligibility needs prio > threshold >= 0,
  // so a priority-0 source can never win.
  // --------------------------------------------------------------------------
  always_comb begin
    best_prio = 2'd0;
    win_id    = 5'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending_q[i] && enable_q[i] &&
          (prio_q[2*i +: 2] > thresh_q) &&
          (prio_q[2*i +: 2] > best_prio)) begin
        best_prio = prio_q[2*i +: 2];
        win_id    = 5'(i + 1);
      end
    end
  end

  assign claim_fire    = read_en && (addr == ADDR_CLAIM) &&
                         (state_q == ST_REQ) && (win_id != 5'd0);
  assign complete_fire = write_en && (addr == ADDR_CLAIM) &&
                         (state_q == ST_SERVICE) && (data_in[4:0] == svc_id_q);

  // --------------------------------------------------------------------------
  // Pending register: a set in the same cycle as a clear wins.
  // --------------------------------------------------------------------------
  always_comb begin
    clr_wr    = '0;
    clr_claim = '0;
    if (write_en && (addr == ADDR_PENDING)) begin
      clr_wr = data_in[NUM_SRC-1:0];
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      clr_claim[i] = claim_fire && (win_id == 5'(i + 1));
    end
    pending_d = (pending_q & ~(clr_wr | clr_claim)) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // --------------------------------------------------------------------------
  // Claim / complete FSM with registered request output
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      svc_id_q   <= 5'd0;
      intr_ext_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_id != 5'd0) begin
            state_q    <= ST_REQ;
            intr_ext_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (claim_fire) begin
            svc_id_q   <= win_id;
            state_q    <= ST_SERVICE;
            intr_ext_q <= 1'b0;
          end else if (win_id == 5'd0) begin
            // Source disabled or cleared before software claimed it.
            state_q    <= ST_IDLE;
            intr_ext_q <= 1'b0;
          end else begin
            intr_ext_q <= 1'b1;
          end
        end
        ST_SERVICE: begin
          intr_ext_q <= 1'b0;
          if (complete_fire) begin
            svc_id_q <= 5'd0;
            state_q  <= ST_IDLE;
          end
        end
        default: begin
          state_q    <= ST_IDLE;
          intr_ext_q <= 1'b0;
        end
      endcase
    end
  end

  assign intr_ext = intr_ext_q;

  // --------------------------------------------------------------------------
  // Read mux. A strobed CLAIM read outside REQ returns 0. An unstrobed read of
  // address 4 shows the current winner, or the in-service ID.
  // --------------------------------------------------------------------------
  always_comb begin
    data_out = 32'd0;
    case (addr)
      ADDR_ENABLE:    data_out[NUM_SRC-1:0] = enable_q;
      ADDR_PRIORITY:  data_out[PRIO_W-1:0]  = prio_q;
      ADDR_THRESHOLD: data_out[1:0]         = thresh_q;
      ADDR_PENDING:   data_out[NUM_SRC-1:0] = pending_q;
      ADDR_CLAIM: begin
        if (read_en && (state_q != ST_REQ)) begin
          data_out = 32'd0;
        end else if (state_q == ST_SERVICE) begin
          data_out[4:0] = svc_id_q;
        end else begin
          data_out[4:0] = win_id;
        end
      end
`ifdef IRQ_EDGE_EN
      ADDR_EDGE:      data_out[NUM_SRC-1:0] = edge_q;
`endif
      default:        data_out = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_irq_arbiter
// Purpose  : Scoreboard bench for irq_arbiter. Stimulus tasks push expected
//            read data / request values into queues. A negedge monitor pops
//            and compares whenever a read or request probe is presented.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_arbiter;

  localparam int NUM_SRC = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic [NUM_SRC-1:0] src_irq;
  logic [2:0]         addr;
  logic [31:0]        data_in;
  logic               write_en;
  logic               read_en;
  logic [31:0]        data_out;
  logic               intr_ext;

  logic peek_rd = 1'b0;
  logic probe   = 1'b0;

  typedef struct {
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t q_rd[$];
  exp_t q_irq[$];

  int total = 0;
  int bad   = 0;

  irq_arbiter #(.NUM_SRC(NUM_SRC)) dut (
    .clk      (clk),
    .reset    (reset),
    .src_irq  (src_irq),
    .addr     (addr),
    .data_in  (data_in),
    .write_en (write_en),
    .read_en  (read_en),
    .data_out (data_out),
    .intr_ext (intr_ext)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Monitor: compares on the falling edge, away from the active edge.
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    exp_t e;
    if (read_en || peek_rd) begin
      total++;
      if (q_rd.size() == 0) begin
        bad++;
        $display("FAIL rd_underflow: read presented with no expected value, got 0x%08h", data_out);
      end else begin
        e = q_rd.pop_front();
        if (data_out !== e.val) begin
          bad++;
          $display("FAIL %s: data_out=0x%08h expected 0x%08h", e.name, data_out, e.val);
        end
      end
    end
    if (probe) begin
      total++;
      if (q_irq.size() == 0) begin
        bad++;
        $display("FAIL irq_underflow: probe with no expected value, got %0b", intr_ext);
      end else begin
        e = q_irq.pop_front();
        if (intr_ext !== e.val[0]) begin
          bad++;
          $display("FAIL %s: intr_ext=%0b expected %0b", e.name, intr_ext, e.val[0]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (called at posedge+1, return at next posedge+1)
  // --------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    addr     = a;
    data_in  = d;
    write_en = 1'b1;
    cyc();
    write_en = 1'b0;
    data_in  = 32'd0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e,
                    input string nm, input bit strobe);
    exp_t x;
    x.name = nm;
    x.val  = e;
    q_rd.push_back(x);
    addr = a;
    if (strobe) read_en = 1'b1;
    else        peek_rd = 1'b1;
    cyc();
    read_en = 1'b0;
    peek_rd = 1'b0;
  endtask

  task automatic chk_irq(input logic e, input string nm);
    exp_t x;
    x.name = nm;
    x.val  = {31'd0, e};
    q_irq.push_back(x);
    probe = 1'b1;
    cyc();
    probe = 1'b0;
  endtask

  task automatic pulse(input logic [NUM_SRC-1:0] v);
    src_irq = v;
    cyc();
    src_irq = '0;
  endtask

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  initial begin
    reset    = 1'b1;
    src_irq  = '0;
    addr     = 3'd0;
    data_in  = 32'd0;
    write_en = 1'b0;
    read_en  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset sweep
    for (int a = 0; a < 8; a++) rd(3'(a), 32'd0, $sformatf("reset_rd%0d", a), 1'b1);
    chk_irq(1'b0, "reset_irq");

    // Latency: request exactly 4 edges after the rising source edge
    wr(3'd0, 32'h1);
    wr(3'd1, 32'h1);
    wr(3'd2, 32'h0);
    pulse(8'h01);
    chk_irq(1'b0, "lat_e1");
    chk_irq(1'b0, "lat_e2");
    chk_irq(1'b0, "lat_e3");
    chk_irq(1'b1, "lat_e4");
    rd(3'd4, 32'd1, "lat_claim", 1'b1);
    chk_irq(1'b0, "lat_fall");
    wr(3'd4, 32'd1);
    chk_irq(1'b0, "lat_idle0");
    chk_irq(1'b0, "lat_idle1");
    rd(3'd3, 32'd0, "lat_pend", 1'b1);

    // Priority and tie-break: sources 2,3,5 with priorities 2,3,3
    wr(3'd0, 32'h16);
    wr(3'd1, 32'h338);
    pulse(8'h16);
    repeat (3) cyc();
    chk_irq(1'b1, "prio_req");
    rd(3'd3, 32'h16, "prio_pend", 1'b1);
    rd(3'd4, 32'd3, "claim_a", 1'b1);
    rd(3'd4, 32'd3, "svc_peek", 1'b0);
    wr(3'd4, 32'd5);                          // wrong ID, ignored
    chk_irq(1'b0, "mismatch_irq");
    rd(3'd4, 32'd3, "mismatch_peek", 1'b0);
    rd(3'd3, 32'h12, "pend_after_claim", 1'b1);
    wr(3'd4, 32'd3);
    chk_irq(1'b0, "cmp_a_idle");
    chk_irq(1'b1, "cmp_a_rereq");
    rd(3'd4, 32'd5, "claim_b", 1'b1);
    wr(3'd4, 32'd5);
    cyc();
    rd(3'd4, 32'd2, "claim_c", 1'b1);
    wr(3'd4, 32'd2);
    chk_irq(1'b0, "prio_done0");
    chk_irq(1'b0, "prio_done1");
    rd(3'd3, 32'd0, "prio_pend_empty", 1'b1);

    // Threshold blocks a priority-2 source
    wr(3'd2, 32'd2);
    wr(3'd0, 32'h2);
    pulse(8'h02);
    repeat (4) cyc();
    chk_irq(1'b0, "thr_block");
    rd(3'd3, 32'h2, "thr_pend", 1'b1);
    rd(3'd4, 32'd0, "thr_win", 1'b0);
    rd(3'd2, 32'd2, "thr_reg", 1'b1);
    wr(3'd3, 32'h2);
    rd(3'd3, 32'd0, "thr_clr", 1'b1);

    // Disable while in REQ
    wr(3'd2, 32'd0);
    pulse(8'h02);
    repeat (3) cyc();
    chk_irq(1'b1, "dis_req");
    wr(3'd0, 32'd0);
    chk_irq(1'b1, "dis_lag");
    chk_irq(1'b0, "dis_idle");
    wr(3'd3, 32'h2);

    // Edge vs level with source 1 held high
    wr(3'd0, 32'h1);
    wr(3'd1, 32'h1);
    wr(3'd5, 32'h1);
`ifdef IRQ_EDGE_EN
    rd(3'd5, 32'h1, "edge_reg", 1'b1);
`else
    rd(3'd5, 32'h0, "edge_reg", 1'b1);
`endif
    src_irq = 8'h01;
    repeat (4) cyc();
    chk_irq(1'b1, "hold_req");
    rd(3'd4, 32'd1, "hold_claim", 1'b1);
`ifdef IRQ_EDGE_EN
    rd(3'd3, 32'h0, "hold_pend", 1'b1);
`else
    rd(3'd3, 32'h1, "hold_pend", 1'b1);
`endif
    wr(3'd4, 32'd1);
    chk_irq(1'b0, "hold_idle");
`ifdef IRQ_EDGE_EN
    chk_irq(1'b0, "hold_rereq");
`else
    chk_irq(1'b1, "hold_rereq");
`endif
    src_irq = '0;
    repeat (3) cyc();
    wr(3'd3, 32'h1);
    repeat (2) cyc();
    chk_irq(1'b0, "hold_quiet");

    // Reset mid-service
    pulse(8'h01);
    repeat (3) cyc();
    chk_irq(1'b1, "rst_req");
    rd(3'd4, 32'd1, "rst_claim", 1'b1);
    rd(3'd4, 32'd1, "rst_svc_peek", 1'b0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk_irq(1'b0, "rst_irq");
    for (int a = 0; a < 8; a++) rd(3'(a), 32'd0, $sformatf("rst_rd%0d", a), 1'b1);

    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
